register_file_sb: RTL and testbench

Parametrised successor to the single-write, dual-read register bank for the ARC MIPS pipeline. Adds configurable width and depth, an asynchronous clear, a hardwired zero register, and write-to-read bypass. A per-register pending-write scoreboard lets decode detect RAW hazards and stall WAW issues. Sits between decode (read, issue) and writeback (write).

---
 rtl/register_file_sb.sv | 123 ++++++++++++
 tb/tb_register_file_sb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file_sb.sv
// Dual-read, single-write register file with a pending-write scoreboard for hazard detection.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_addr_Rs,
  input  logic [ADDR_W-1:0] i_addr_Rt,
  output logic [DATA_W-1:0] o_data_Rs,
  output logic [DATA_W-1:0] o_data_Rt,
  output logic              o_busy_Rs,
  output logic              o_busy_Rt,
  input  logic              i_con_Issue,
  input  logic [ADDR_W-1:0] i_addr_Dst,
  output logic              o_stall,
  input  logic              i_con_RegWr,
  input  logic [ADDR_W-1:0] i_addr_Rd,
  input  logic [DATA_W-1:0] i_data_Rd,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam int N_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [N_REGS];
  logic [N_REGS-1:0] r_pending;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_wr_en;
  logic w_issue_req;
  logic w_issue_en;
  logic w_byp_rs;
  logic w_byp_rt;
  logic w_clear_now;
  logic w_stall;

  // Qualify with reset so nothing presented during reset leaks to the outputs.
  assign w_wr_en     = i_rst_n & i_con_RegWr & (i_addr_Rd != {ADDR_W{1'b0}});
  assign w_issue_req = i_rst_n & i_con_Issue & (i_addr_Dst != {ADDR_W{1'b0}});

`ifdef REGFILE_BYPASS_EN
  assign w_byp_rs    = w_wr_en & (i_addr_Rs == i_addr_Rd);
  assign w_byp_rt    = w_wr_en & (i_addr_Rt == i_addr_Rd);
  assign w_clear_now = w_wr_en & (i_addr_Dst == i_addr_Rd);
`else
  assign w_byp_rs    = 1'b0;
  assign w_byp_rt    = 1'b0;
  assign w_clear_now = 1'b0;
`endif

  assign w_stall     = w_issue_req & r_pending[i_addr_Dst] & ~w_clear_now;
  assign w_issue_en  = w_issue_req & ~w_stall;
  assign o_stall     = w_stall;
  assign o_stall_cnt = r_stall_cnt;

  // Read port A: forwarded writeback data, hardwired zero, or stored contents.
  always_comb begin
    o_data_Rs = {DATA_W{1'b0}};
    if (w_byp_rs) begin
      o_data_Rs = i_data_Rd;
    end else if (i_addr_Rs == {ADDR_W{1'b0}}) begin
      o_data_Rs = {DATA_W{1'b0}};
    end else begin
      o_data_Rs = r_regs[i_addr_Rs];
    end
  end

  // Read port B: same selection as port A.
  always_comb begin
    o_data_Rt = {DATA_W{1'b0}};
    if (w_byp_rt) begin
      o_data_Rt = i_data_Rd;
    end else if (i_addr_Rt == {ADDR_W{1'b0}}) begin
      o_data_Rt = {DATA_W{1'b0}};
    end else begin
      o_data_Rt = r_regs[i_addr_Rt];
    end
  end

  assign o_busy_Rs = r_pending[i_addr_Rs] & ~w_byp_rs;
  assign o_busy_Rt = r_pending[i_addr_Rt] & ~w_byp_rt;

  // Register storage; entry 0 is never written and stays zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_REGS; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (w_wr_en) begin
      r_regs[i_addr_Rd] <= i_data_Rd;
    end else begin
      r_regs[i_addr_Rd] <= r_regs[i_addr_Rd];
    end
  end

  // Scoreboard: the issue set is ordered after the writeback clear so a new producer wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= {N_REGS{1'b0}};
    end else begin
      if (w_wr_en) begin
        r_pending[i_addr_Rd] <= 1'b0;
      end
      if (w_issue_en) begin
        r_pending[i_addr_Dst] <= 1'b1;
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed self-checking bench for register_file_sb; expectations follow REGFILE_BYPASS_EN.
`timescale 1ns/1ps
module tb_register_file_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              i_clk;
  logic              i_rst_n;
  logic [ADDR_W-1:0] i_addr_Rs;
  logic [ADDR_W-1:0] i_addr_Rt;
  logic [DATA_W-1:0] o_data_Rs;
  logic [DATA_W-1:0] o_data_Rt;
  logic              o_busy_Rs;
  logic              o_busy_Rt;
  logic              i_con_Issue;
  logic [ADDR_W-1:0] i_addr_Dst;
  logic              o_stall;
  logic              i_con_RegWr;
  logic [ADDR_W-1:0] i_addr_Rd;
  logic [DATA_W-1:0] i_data_Rd;
  logic [CNT_W-1:0]  o_stall_cnt;

  int n_cmp;
  int n_fail;

  register_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_addr_Rs   (i_addr_Rs),
    .i_addr_Rt   (i_addr_Rt),
    .o_data_Rs   (o_data_Rs),
    .o_data_Rt   (o_data_Rt),
    .o_busy_Rs   (o_busy_Rs),
    .o_busy_Rt   (o_busy_Rt),
    .i_con_Issue (i_con_Issue),
    .i_addr_Dst  (i_addr_Dst),
    .o_stall     (o_stall),
    .i_con_RegWr (i_con_RegWr),
    .i_addr_Rd   (i_addr_Rd),
    .i_data_Rd   (i_data_Rd),
    .o_stall_cnt (o_stall_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    i_rst_n     = 1'b0;
    i_addr_Rs   = 5'd0;
    i_addr_Rt   = 5'd0;
    i_con_Issue = 1'b0;
    i_addr_Dst  = 5'd0;
    i_con_RegWr = 1'b0;
    i_addr_Rd   = 5'd0;
    i_data_Rd   = 32'd0;
    #2;
    chk("por_data", o_data_Rs, 32'd0);
    chk("por_busy", 32'(o_busy_Rs), 32'd0);
    chk("por_cnt", 32'(o_stall_cnt), 32'd0);
    tick();
    i_rst_n = 1'b1;

    // Build up state: r6 pending, r5 written, one stall counted.
    i_con_Issue = 1'b1; i_addr_Dst = 5'd6;
    tick();
    i_con_Issue = 1'b0;
    i_con_RegWr = 1'b1; i_addr_Rd = 5'd5; i_data_Rd = 32'hDEADBEEF;
    tick();
    i_con_RegWr = 1'b0;
    i_addr_Rs = 5'd5; i_addr_Rt = 5'd6;
    #1;
    chk("wr_r5", o_data_Rs, 32'hDEADBEEF);
    chk("busy_r6", 32'(o_busy_Rt), 32'd1);
    i_con_Issue = 1'b1; i_addr_Dst = 5'd6;
    #1;
    chk("waw_r6", 32'(o_stall), 32'd1);
    tick();
    i_con_Issue = 1'b0;
    chk("cnt_one", 32'(o_stall_cnt), 32'd1);

    // Asynchronous reset mid-cycle, with issue and write presented during reset.
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_data", o_data_Rs, 32'd0);
    chk("rst_busy", 32'(o_busy_Rt), 32'd0);
    chk("rst_cnt", 32'(o_stall_cnt), 32'd0);
    i_con_Issue = 1'b1; i_addr_Dst = 5'd6;
    i_con_RegWr = 1'b1; i_addr_Rd = 5'd5; i_data_Rd = 32'h0BADF00D;
    #1;
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_nobyp", o_data_Rs, 32'd0);
    tick();
    i_con_Issue = 1'b0; i_con_RegWr = 1'b0;
    i_rst_n = 1'b1;
    #1;
    chk("rst_wr_ign", o_data_Rs, 32'd0);
    chk("rst_iss_ign", 32'(o_busy_Rt), 32'd0);

    // Zero register: writes and issues to r0 have no effect.
    i_addr_Rs = 5'd0;
    i_con_RegWr = 1'b1; i_addr_Rd = 5'd0; i_data_Rd = 32'h12345678;
    i_con_Issue = 1'b1; i_addr_Dst = 5'd0;
    #1;
    chk("r0_stall", 32'(o_stall), 32'd0);
    chk("r0_data_now", o_data_Rs, 32'd0);
    tick();
    i_con_RegWr = 1'b0; i_con_Issue = 1'b0;
    #1;
    chk("r0_data", o_data_Rs, 32'd0);
    chk("r0_busy", 32'(o_busy_Rs), 32'd0);

    // Bypass on both read ports.
    i_con_RegWr = 1'b1; i_addr_Rd = 5'd7; i_data_Rd = 32'h11111111;
    tick();
    i_addr_Rs = 5'd7; i_addr_Rt = 5'd7;
    i_data_Rd = 32'hA5A5A5A5;
    #1;
    chk("byp_rs", o_data_Rs, BYP ? 32'hA5A5A5A5 : 32'h11111111);
    chk("byp_rt", o_data_Rt, BYP ? 32'hA5A5A5A5 : 32'h11111111);
    tick();
    i_con_RegWr = 1'b0;
    #1;
    chk("post_rs", o_data_Rs, 32'hA5A5A5A5);
    chk("post_rt", o_data_Rt, 32'hA5A5A5A5);

    // RAW busy on r9.
    i_con_Issue = 1'b1; i_addr_Dst = 5'd9;
    tick();
    i_con_Issue = 1'b0;
    i_addr_Rs = 5'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("raw_busy", 32'(o_busy_Rs), 32'd1);
      tick();
    end
    i_con_RegWr = 1'b1; i_addr_Rd = 5'd9; i_data_Rd = 32'h00000099;
    #1;
    chk("raw_wb_busy", 32'(o_busy_Rs), BYP ? 32'd0 : 32'd1);
    tick();
    i_con_RegWr = 1'b0;
    #1;
    chk("raw_after", 32'(o_busy_Rs), 32'd0);
    chk("raw_data", o_data_Rs, 32'h00000099);

    // WAW stall on r3.
    i_con_Issue = 1'b1; i_addr_Dst = 5'd3;
    #1;
    chk("waw_first", 32'(o_stall), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("waw_stall", 32'(o_stall), 32'd1);
      tick();
    end
    chk("waw_cnt4", 32'(o_stall_cnt), 32'd4);
    i_con_RegWr = 1'b1; i_addr_Rd = 5'd3; i_data_Rd = 32'h00000033;
    #1;
    chk("waw_wb_stall", 32'(o_stall), BYP ? 32'd0 : 32'd1);
    tick();
    i_con_RegWr = 1'b0; i_con_Issue = 1'b0;
    i_addr_Rs = 5'd3;
    #1;
    chk("waw_pend", 32'(o_busy_Rs), BYP ? 32'd1 : 32'd0);
    chk("waw_cnt_end", 32'(o_stall_cnt), BYP ? 32'd4 : 32'd5);

    // Saturation: fresh producer on r4, then hold the WAW issue for 20 cycles.
    i_con_Issue = 1'b1; i_addr_Dst = 5'd4;
    tick();
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("sat_stall", 32'(o_stall), 32'd1);
      tick();
    end
    chk("sat_cnt", 32'(o_stall_cnt), 32'd15);
    tick();
    chk("sat_hold", 32'(o_stall_cnt), 32'd15);
    i_con_Issue = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
